// File: rtl/hazard_detection_unit.sv
// Pipeline hazard control: load-use bubbles, taken-branch flushes and data-memory
// wait freezes, with a sticky memory-timeout flag and a stalled-cycle counter.
module hazard_detection_unit #(
  parameter int MEM_TIMEOUT = 200
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [4:0]  i_rs1_IFID_addr,
  input  logic [4:0]  i_rs2_IFID_addr,
  input  logic [6:0]  i_opcode_IFID,
  input  logic [4:0]  i_rd_waddr_IDEX,
  input  logic        i_clu_MemRead_IDEX,
  input  logic        i_branch_taken_EX,
  input  logic        i_dmem_busy,
  output logic        o_stall_PC,
  output logic        o_stall_IFID,
  output logic        o_flush_IFID,
  output logic        o_flush_IDEX,
  output logic        o_freeze,
  output logic        o_mem_timeout,
  output logic [31:0] o_stall_count,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);

  state_t      state, state_next;
  logic [7:0]  wait_cnt, wait_next;
  logic        rs1_used, rs2_used, is_store;
  logic        rs1_match, rs2_match, load_use;

  assign o_dbg_state = state;

  // Store data (rs2) fed by a load is covered by MEM-to-MEM forwarding, so it never stalls.
  assign rs1_used  = !(i_opcode_IFID == OP_LUI || i_opcode_IFID == OP_AUIPC ||
                       i_opcode_IFID == OP_JAL);
  assign rs2_used  = (i_opcode_IFID == OP_RTYPE || i_opcode_IFID == OP_STORE ||
                      i_opcode_IFID == OP_BRANCH);
  assign is_store  = (i_opcode_IFID == OP_STORE);
  assign rs1_match = rs1_used && (i_rs1_IFID_addr == i_rd_waddr_IDEX);
  assign rs2_match = rs2_used && !is_store && (i_rs2_IFID_addr == i_rd_waddr_IDEX);
  assign load_use  = i_clu_MemRead_IDEX && (i_rd_waddr_IDEX != 5'd0) &&
                     (rs1_match || rs2_match) && (state != LU_STALL);

  always_comb begin
    o_stall_PC   = 1'b0;
    o_stall_IFID = 1'b0;
    o_flush_IFID = 1'b0;
    o_flush_IDEX = 1'b0;
    o_freeze     = 1'b0;
    state_next   = RUN;
    if (i_rst) begin
      state_next = RUN;
    end else if (i_dmem_busy) begin
      o_freeze     = 1'b1;
      o_stall_PC   = 1'b1;
      o_stall_IFID = 1'b1;
      state_next   = MEM_WAIT;
    end else if (i_branch_taken_EX) begin
      o_flush_IFID = 1'b1;
      o_flush_IDEX = 1'b1;
      state_next   = RUN;
    end else if (load_use) begin
      o_stall_PC   = 1'b1;
      o_stall_IFID = 1'b1;
      o_flush_IDEX = 1'b1;
      state_next   = LU_STALL;
    end
  end

  assign wait_next = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= RUN;
      wait_cnt      <= 8'd0;
      o_mem_timeout <= 1'b0;
      o_stall_count <= 32'd0;
    end else begin
      state <= state_next;
      if (i_dmem_busy) begin
        wait_cnt <= wait_next;
        if (wait_next == TIMEOUT_VAL) o_mem_timeout <= 1'b1;
      end else begin
        wait_cnt <= 8'd0;
      end
      if (o_stall_PC && (o_stall_count != 32'hFFFF_FFFF))
        o_stall_count <= o_stall_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed-vector bench for hazard_detection_unit: the driver pushes the expected
// per-cycle response; a monitor pops and compares on the falling edge.
module tb_hazard_detection_unit;

  localparam int W = 38;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  // control order: {stall_PC, stall_IFID, flush_IFID, flush_IDEX, freeze}
  localparam logic [4:0] C_NONE   = 5'b00000;
  localparam logic [4:0] C_STALL  = 5'b11010;
  localparam logic [4:0] C_FLUSH  = 5'b00110;
  localparam logic [4:0] C_FREEZE = 5'b11001;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1, rs2, rd;
  logic [6:0]  opcode;
  logic        mem_read, branch_taken, dmem_busy;
  logic        stall_pc, stall_ifid, flush_ifid, flush_idex, freeze, mem_timeout;
  logic [31:0] stall_count;
  logic [1:0]  dbg_state;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;
  bit           drive_done = 1'b0;

  hazard_detection_unit #(.MEM_TIMEOUT(4)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_rs1_IFID_addr    (rs1),
    .i_rs2_IFID_addr    (rs2),
    .i_opcode_IFID      (opcode),
    .i_rd_waddr_IDEX    (rd),
    .i_clu_MemRead_IDEX (mem_read),
    .i_branch_taken_EX  (branch_taken),
    .i_dmem_busy        (dmem_busy),
    .o_stall_PC         (stall_pc),
    .o_stall_IFID       (stall_ifid),
    .o_flush_IFID       (flush_ifid),
    .o_flush_IDEX       (flush_idex),
    .o_freeze           (freeze),
    .o_mem_timeout      (mem_timeout),
    .o_stall_count      (stall_count),
    .o_dbg_state        (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver: one vector per cycle, applied just after the rising edge
  task automatic drive(input string nm, input logic r, input logic [6:0] op,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d,
                       input logic mr, input logic br, input logic busy,
                       input logic [4:0] ctl, input logic to, input logic [31:0] cnt);
    @(posedge clk);
    #1;
    rst = r; opcode = op; rs1 = a1; rs2 = a2; rd = d;
    mem_read = mr; branch_taken = br; dmem_busy = busy;
    exp_q.push_back({ctl, to, cnt});
    name_q.push_back(nm);
  endtask

  // monitor / scoreboard
  initial begin
    logic [W-1:0] exp_v, act_v;
    string        nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        nm    = name_q.pop_front();
        act_v = {stall_pc, stall_ifid, flush_ifid, flush_idex, freeze, mem_timeout, stall_count};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL %s: ctl=%b to=%b cnt=%0d, expected ctl=%b to=%b cnt=%0d",
                   nm, act_v[37:33], act_v[32], act_v[31:0],
                   exp_v[37:33], exp_v[32], exp_v[31:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; opcode = OP_ADDI; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    mem_read = 1'b0; branch_taken = 1'b0; dmem_busy = 1'b0;
    repeat (2) @(posedge clk);
    //     name                 rst op        rs1 rs2 rd mr br bz  ctl       to cnt
    drive("reset_forces_zero",  1, OP_RTYPE,  5,  1,  5, 1, 0, 0, C_NONE,   0, 0);
    drive("lu_add_rs1",         0, OP_RTYPE,  5,  1,  5, 1, 0, 0, C_STALL,  0, 0);
    drive("lu_single_bubble",   0, OP_RTYPE,  5,  1,  5, 1, 0, 0, C_NONE,   0, 1);
    drive("sw_data_no_stall",   0, OP_STORE,  2,  5,  5, 1, 0, 0, C_NONE,   0, 1);
    drive("sw_base_stall",      0, OP_STORE,  5,  2,  5, 1, 0, 0, C_STALL,  0, 1);
    drive("idle_after_sw",      0, OP_ADDI,   0,  0,  0, 0, 0, 0, C_NONE,   0, 2);
    drive("lu_add_rs2",         0, OP_RTYPE,  1,  5,  5, 1, 0, 0, C_STALL,  0, 2);
    drive("idle_after_rs2",     0, OP_ADDI,   0,  0,  0, 0, 0, 0, C_NONE,   0, 3);
    drive("lw_x0_no_stall",     0, OP_RTYPE,  0,  0,  0, 1, 0, 0, C_NONE,   0, 3);
    drive("lui_rs1_unused",     0, OP_LUI,    5,  0,  5, 1, 0, 0, C_NONE,   0, 3);
    drive("addi_rs2_unused",    0, OP_ADDI,   1,  5,  5, 1, 0, 0, C_NONE,   0, 3);
    drive("branch_over_lu",     0, OP_RTYPE,  5,  1,  5, 1, 1, 0, C_FLUSH,  0, 3);
    drive("busy_branch_1",      0, OP_ADDI,   0,  0,  0, 0, 1, 1, C_FREEZE, 0, 3);
    drive("busy_branch_2",      0, OP_ADDI,   0,  0,  0, 0, 1, 1, C_FREEZE, 0, 4);
    drive("busy_branch_3",      0, OP_ADDI,   0,  0,  0, 0, 1, 1, C_FREEZE, 0, 5);
    drive("branch_after_busy",  0, OP_ADDI,   0,  0,  0, 0, 1, 0, C_FLUSH,  0, 6);
    for (int i = 0; i < 6; i++)
      drive($sformatf("timeout_busy_%0d", i + 1), 0, OP_ADDI, 0, 0, 0, 0, 0, 1,
            C_FREEZE, (i >= 4) ? 1'b1 : 1'b0, 32'(6 + i));
    drive("timeout_sticky",     0, OP_ADDI,   0,  0,  0, 0, 0, 0, C_NONE,   1, 12);
    drive("busy_over_lu",       0, OP_RTYPE,  5,  1,  5, 1, 0, 1, C_FREEZE, 1, 12);
    drive("busy_hold",          0, OP_ADDI,   0,  0,  0, 0, 0, 1, C_FREEZE, 1, 13);
    drive("rst_in_mem_wait",    1, OP_ADDI,   0,  0,  0, 0, 1, 1, C_NONE,   1, 14);
    drive("after_rst_clear",    0, OP_ADDI,   0,  0,  0, 0, 0, 0, C_NONE,   0, 0);
    drive("lu_before_rst",      0, OP_RTYPE,  5,  1,  5, 1, 0, 0, C_STALL,  0, 0);
    drive("rst_in_lu_stall",    1, OP_RTYPE,  5,  1,  5, 1, 0, 0, C_NONE,   0, 1);
    drive("after_rst_lu",       0, OP_ADDI,   0,  0,  0, 0, 0, 0, C_NONE,   0, 0);
    drive_done = 1'b1;
  end

  // final report
  initial begin
    int budget;
    budget = 0;
    while (!(drive_done && exp_q.size() == 0) && budget < 1000) begin
      @(posedge clk);
      budget++;
    end
    if (budget >= 1000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending=%0d, expected 0", exp_q.size());
    end
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
